// File: rtl/mem_access_stage.sv
// MEM stage: takes one EX result per handshake and issues loads/stores over a req/resp port.
// It builds store lane masks, aligns and extends load data, and presents a registered 1-cycle WB result.
module mem_access_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [XLEN-1:0]       ex_alu_res,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic [3:0]            ex_mem_op,
  input  logic                  ex_reg_wen,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_pc,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [XLEN-1:0]       dmem_req_addr,
  output logic                  dmem_req_wen,
  output logic [XLEN-1:0]       dmem_req_wdata,
  output logic [7:0]            dmem_req_wmask,
  input  logic                  dmem_resp_valid,
  input  logic [XLEN-1:0]       dmem_resp_rdata,
  output logic                  wb_valid,
  output logic                  wb_reg_wen,
  output logic [REG_ADDR_W-1:0] wb_reg_waddr,
  output logic [XLEN-1:0]       wb_data,
  output logic [XLEN-1:0]       wb_pc,
  output logic                  misalign_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] state;

  // Decode of the incoming op; codes 12-15 fall through as plain ALU results.
  logic       d_load, d_store, d_uns, d_mis;
  logic [1:0] d_size;
  logic [2:0] off;
  logic [7:0] d_base, d_mask;

  always_comb begin
    d_load  = 1'b0;
    d_store = 1'b0;
    d_uns   = 1'b0;
    d_size  = 2'd0;
    case (ex_mem_op)
      4'd1:  begin d_load  = 1'b1; d_size = 2'd0; end
      4'd2:  begin d_load  = 1'b1; d_size = 2'd1; end
      4'd3:  begin d_load  = 1'b1; d_size = 2'd2; end
      4'd4:  begin d_load  = 1'b1; d_size = 2'd3; end
      4'd5:  begin d_load  = 1'b1; d_size = 2'd0; d_uns = 1'b1; end
      4'd6:  begin d_load  = 1'b1; d_size = 2'd1; d_uns = 1'b1; end
      4'd7:  begin d_load  = 1'b1; d_size = 2'd2; d_uns = 1'b1; end
      4'd8:  begin d_store = 1'b1; d_size = 2'd0; end
      4'd9:  begin d_store = 1'b1; d_size = 2'd1; end
      4'd10: begin d_store = 1'b1; d_size = 2'd2; end
      4'd11: begin d_store = 1'b1; d_size = 2'd3; end
      default: ;
    endcase
    off = ex_alu_res[2:0];
    case (d_size)
      2'd0:    begin d_mis = 1'b0;             d_base = 8'h01; end
      2'd1:    begin d_mis = off[0];           d_base = 8'h03; end
      2'd2:    begin d_mis = (off[1:0] != 0);  d_base = 8'h0F; end
      default: begin d_mis = (off != 3'd0);    d_base = 8'hFF; end
    endcase
    d_mis  = d_mis & (d_load | d_store);
    d_mask = d_store ? (d_base << off) : 8'h00;
  end

  logic                  ld_q, uns_q, wb_wen_q, mis_q;
  logic [1:0]            size_q;
  logic [2:0]            off_q;
  logic [XLEN-1:0]       addr_q, wdata_q, data_q, pc_q;
  logic                  wen_q;
  logic [7:0]            wmask_q;
  logic [REG_ADDR_W-1:0] rd_q;

  // Load alignment and extension from the returned word.
  logic [XLEN-1:0] ld_sh, ld_val;
  always_comb begin
    ld_sh = dmem_resp_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    ld_val = uns_q ? {{(XLEN-8){1'b0}}, ld_sh[7:0]}
                              : {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
      2'd1:    ld_val = uns_q ? {{(XLEN-16){1'b0}}, ld_sh[15:0]}
                              : {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      2'd2:    ld_val = uns_q ? {{(XLEN-32){1'b0}}, ld_sh[31:0]}
                              : {{(XLEN-32){ld_sh[31]}}, ld_sh[31:0]};
      default: ld_val = ld_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ld_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= 2'd0;
      off_q    <= 3'd0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= 8'h00;
      wb_wen_q <= 1'b0;
      mis_q    <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      pc_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (ex_valid) begin
          ld_q     <= d_load;
          uns_q    <= d_uns;
          size_q   <= d_size;
          off_q    <= off;
          addr_q   <= {ex_alu_res[XLEN-1:3], 3'b000};
          wen_q    <= d_store;
          wdata_q  <= ex_store_data << {off, 3'b000};
          wmask_q  <= d_mask;
          wb_wen_q <= ex_reg_wen & ~d_store & ~d_mis;
          mis_q    <= d_mis;
          rd_q     <= ex_rd;
          data_q   <= ex_alu_res;
          pc_q     <= ex_pc;
          state    <= (d_mis || !(d_load || d_store)) ? S_DONE : S_REQ;
        end
        S_REQ: if (dmem_req_ready) state <= ld_q ? S_RESP : S_DONE;
        S_RESP: if (dmem_resp_valid) begin
          data_q <= ld_val;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ex_ready       = (state == S_IDLE);
  assign dmem_req_valid = (state == S_REQ);
  assign dmem_req_addr  = addr_q;
  assign dmem_req_wen   = wen_q;
  assign dmem_req_wdata = wdata_q;
  assign dmem_req_wmask = wmask_q;
  assign wb_valid       = (state == S_DONE);
  assign wb_reg_wen     = wb_valid & wb_wen_q;
  assign wb_reg_waddr   = rd_q;
  assign wb_data        = data_q;
  assign wb_pc          = pc_q;
  assign misalign_err   = wb_valid & mis_q;

endmodule
